// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants for the register file slice: default geometry of the file
// and the architectural indices of the registers the testbench hooks use.
// No ports (package).
// -----------------------------------------------------------------------------
package regfile_pkg;

   // Default geometry: 32 registers of 32 bits (RV32I).
   localparam int ADDRESS_WIDTH = 5;
   localparam int DATA_WIDTH    = 32;

   // Named architectural registers.
   localparam int REG_ZERO = 0;
   localparam int REG_T0   = 5;
   localparam int REG_A0   = 10;

endpackage

// File: rtl/regfile_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_sb_if
// Bundles the read, write, claim, trigger and debug signals of the register
// file. The pipeline (or testbench) side uses the master modport, the register
// file itself uses the slave modport.
//   ra         : packed read addresses, port i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   rd         : packed read data, same packing as ra
//   busy       : per-port outstanding-write flag
//   we/wa/wd   : write port
//   claim_en/claim_addr : destination claim from issue
//   trigger    : forces the trigger register to 1
//   a0         : stored contents of the exported register
// -----------------------------------------------------------------------------
interface regfile_sb_if #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_READ      = 2
);
   import regfile_pkg::*;

   logic [NUM_READ*ADDRESS_WIDTH-1:0] ra;
   logic [NUM_READ*DATA_WIDTH-1:0]    rd;
   logic [NUM_READ-1:0]               busy;
   logic                              we;
   logic [ADDRESS_WIDTH-1:0]          wa;
   logic [DATA_WIDTH-1:0]             wd;
   logic                              claim_en;
   logic [ADDRESS_WIDTH-1:0]          claim_addr;
   logic                              trigger;
   logic [DATA_WIDTH-1:0]             a0;

   modport master (
      output ra, we, wa, wd, claim_en, claim_addr, trigger,
      input  rd, busy, a0
   );

   modport slave (
      input  ra, we, wa, wd, claim_en, claim_addr, trigger,
      output rd, busy, a0
   );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// One pending bit per register, set by a claim from issue and cleared by the
// write that retires it, plus the per-read-port busy flags used by decode to
// stall on RAW hazards.
//   clk, rst      : clock, asynchronous active-high reset
//   i_we, i_wa    : write port (clears pending)
//   i_claimEn, i_claimAddr : claim (sets pending)
//   i_ra          : packed read addresses
//   o_busy        : per-port busy flags
// -----------------------------------------------------------------------------
module reg_scoreboard #(
   parameter int ADDRESS_WIDTH = regfile_pkg::ADDRESS_WIDTH,
   parameter int NUM_READ      = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_we,
   input  logic [ADDRESS_WIDTH-1:0]          i_wa,
   input  logic                              i_claimEn,
   input  logic [ADDRESS_WIDTH-1:0]          i_claimAddr,
   input  logic [NUM_READ*ADDRESS_WIDTH-1:0] i_ra,
   output logic [NUM_READ-1:0]               o_busy
);
   import regfile_pkg::*;

   localparam int NUM_REGS = 2**ADDRESS_WIDTH;

   logic [NUM_REGS-1:0] r_pending;

   // Pending bits. The claim is tested first so that a claim and a write to the
   // same register in one cycle leave the bit set: the claim belongs to a newer
   // instruction than the one retiring. Bit 0 is never set, so x0 never reads
   // as busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= '0;
      end else begin
         for (int k = 1; k < NUM_REGS; k++) begin
            if (i_claimEn && i_claimAddr == ADDRESS_WIDTH'(k)) begin
               r_pending[k] <= 1'b1;
            end else if (i_we && i_wa == ADDRESS_WIDTH'(k)) begin
               r_pending[k] <= 1'b0;
            end
         end
      end
   end

   // A write presented in the same cycle is forwarded by the bypass, so it
   // already satisfies the hazard and masks the busy flag.
   for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_busy
      logic [ADDRESS_WIDTH-1:0] w_ra;
      assign w_ra = i_ra[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      assign o_busy[gi] = (w_ra != ADDRESS_WIDTH'(REG_ZERO)) && r_pending[w_ra] &&
                          !(i_we && i_wa == w_ra);
   end

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// RISC-V integer register file with NUM_READ combinational read ports, one
// write port with same-cycle write-to-read bypass, hardwired-zero x0, a
// trigger that forces TRIGGER_REG to 1, a debug export of OUT_REG and a
// pending-write scoreboard.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : regfile_sb_if slave (read/write/claim/trigger/debug signals)
// -----------------------------------------------------------------------------
module regfile_sb #(
   parameter int ADDRESS_WIDTH = regfile_pkg::ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = regfile_pkg::DATA_WIDTH,
   parameter int NUM_READ      = 2,
   parameter int TRIGGER_REG   = regfile_pkg::REG_T0,
   parameter int OUT_REG       = regfile_pkg::REG_A0
) (
   input logic        clk,
   input logic        rst,
   regfile_sb_if.slave bus
);
   import regfile_pkg::*;

   localparam int NUM_REGS = 2**ADDRESS_WIDTH;

   logic [DATA_WIDTH-1:0] r_regs [1:NUM_REGS-1];
   logic [DATA_WIDTH-1:0] w_file [NUM_REGS];

   // Register storage for x1 upwards. The trigger is checked before the write
   // so that it wins a same-cycle collision on TRIGGER_REG.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 1; k < NUM_REGS; k++) begin
            r_regs[k] <= '0;
         end
      end else begin
         for (int k = 1; k < NUM_REGS; k++) begin
            if (bus.trigger && k == TRIGGER_REG) begin
               r_regs[k] <= DATA_WIDTH'(1);
            end else if (bus.we && bus.wa == ADDRESS_WIDTH'(k)) begin
               r_regs[k] <= bus.wd;
            end
         end
      end
   end

   // Full architectural view with x0 tied to zero, so reads can index it
   // directly without an out-of-range slot.
   always_comb begin
      w_file[0] = '0;
      for (int k = 1; k < NUM_REGS; k++) begin
         w_file[k] = r_regs[k];
      end
   end

   // Read muxes: x0 first, then the bypass from the write port, then storage.
   // The trigger is deliberately not bypassed.
   for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [ADDRESS_WIDTH-1:0] w_ra;
      assign w_ra = bus.ra[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      assign bus.rd[gi*DATA_WIDTH +: DATA_WIDTH] =
         (w_ra == ADDRESS_WIDTH'(REG_ZERO)) ? '0 :
         (bus.we && bus.wa == w_ra)         ? bus.wd :
                                              w_file[w_ra];
   end

   // Debug export comes straight from storage, never from the bypass.
   assign bus.a0 = w_file[ADDRESS_WIDTH'(OUT_REG)];

   reg_scoreboard #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .NUM_READ      (NUM_READ)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .i_we        (bus.we),
      .i_wa        (bus.wa),
      .i_claimEn   (bus.claim_en),
      .i_claimAddr (bus.claim_addr),
      .i_ra        (bus.ra),
      .o_busy      (bus.busy)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
// Drives a 2-port and a 3-port regfile_sb in lockstep (shared write, claim and
// trigger inputs) and compares both against an array-based reference model,
// plus a table of hand-derived vectors and a mid-cycle reset sequence.
// -----------------------------------------------------------------------------
module tb_regfile_sb;
   import regfile_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   regfile_sb_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2)) bus2 ();
   regfile_sb_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(3)) bus3 ();

   // The 3-port instance shares every input except its read addresses.
   assign bus3.we         = bus2.we;
   assign bus3.wa         = bus2.wa;
   assign bus3.wd         = bus2.wd;
   assign bus3.claim_en   = bus2.claim_en;
   assign bus3.claim_addr = bus2.claim_addr;
   assign bus3.trigger    = bus2.trigger;

   regfile_sb #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2),
                .TRIGGER_REG(REG_T0), .OUT_REG(REG_A0))
      dut2 (.clk(clk), .rst(rst), .bus(bus2));

   regfile_sb #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(3),
                .TRIGGER_REG(REG_T0), .OUT_REG(REG_A0))
      dut3 (.clk(clk), .rst(rst), .bus(bus3));

   int checks   = 0;
   int failures = 0;

   // Reference model: architectural contents and pending flags.
   logic [31:0] mRegs [32];
   bit          mPend [32];

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        ce;
      logic [4:0]  ca;
      logic        trig;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] expRd0;
      logic [31:0] expRd1;
      logic [31:0] expRd2;
      logic        expBusy0;
      logic        expBusy1;
      logic [31:0] expA0;
   } vec_t;

   vec_t vecs[$];

   task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] modelRd(input logic [4:0] ra);
      if (ra == 5'd0) return 32'd0;
      if (bus2.we && bus2.wa == ra) return bus2.wd;
      return mRegs[ra];
   endfunction

   function automatic logic modelBusy(input logic [4:0] ra);
      if (ra == 5'd0) return 1'b0;
      return mPend[ra] && !(bus2.we && bus2.wa == ra);
   endfunction

   task automatic modelReset();
      for (int k = 0; k < 32; k++) begin
         mRegs[k] = '0;
         mPend[k] = 1'b0;
      end
   endtask

   // Architectural effect of one clock edge with the current inputs.
   task automatic modelUpdate();
      if (bus2.we && bus2.wa != 5'd0) begin
         mRegs[bus2.wa] = bus2.wd;
         mPend[bus2.wa] = 1'b0;
      end
      if (bus2.trigger) mRegs[REG_T0] = 32'd1;
      if (bus2.claim_en && bus2.claim_addr != 5'd0) mPend[bus2.claim_addr] = 1'b1;
   endtask

   task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ce, input logic [4:0] ca, input logic trig,
                                input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2);
      bus2.we         = we;
      bus2.wa         = wa;
      bus2.wd         = wd;
      bus2.claim_en   = ce;
      bus2.claim_addr = ca;
      bus2.trigger    = trig;
      bus2.ra         = {ra1, ra0};
      bus3.ra         = {ra2, ra1, ra0};
   endtask

   // Compare every output of both instances against the model.
   task automatic checkOutput(input string tag);
      logic [4:0] ra;
      for (int i = 0; i < 2; i++) begin
         ra = bus2.ra[i*5 +: 5];
         checkVal($sformatf("%s rd2[%0d]", tag, i), bus2.rd[i*32 +: 32], modelRd(ra));
         checkVal($sformatf("%s busy2[%0d]", tag, i), 32'(bus2.busy[i]), 32'(modelBusy(ra)));
      end
      for (int i = 0; i < 3; i++) begin
         ra = bus3.ra[i*5 +: 5];
         checkVal($sformatf("%s rd3[%0d]", tag, i), bus3.rd[i*32 +: 32], modelRd(ra));
         checkVal($sformatf("%s busy3[%0d]", tag, i), 32'(bus3.busy[i]), 32'(modelBusy(ra)));
      end
      checkVal($sformatf("%s a0_2", tag), bus2.a0, mRegs[REG_A0]);
      checkVal($sformatf("%s a0_3", tag), bus3.a0, mRegs[REG_A0]);
   endtask

   task automatic tick();
      @(posedge clk);
      modelUpdate();
      #1;
   endtask

   task automatic addVec(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ce, input logic [4:0] ca, input logic trig,
                         input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2,
                         input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                         input logic b0, input logic b1, input logic [31:0] ea0);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.ce = ce; v.ca = ca; v.trig = trig;
      v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2;
      v.expRd0 = e0; v.expRd1 = e1; v.expRd2 = e2;
      v.expBusy0 = b0; v.expBusy1 = b1; v.expA0 = ea0;
      vecs.push_back(v);
   endtask

   initial begin
      modelReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 5'd7, 5'd10, 5'd3);

      // Hand-derived sequence starting from the reset state.
      //     we wa  wd            ce ca  tr ra0 ra1 ra2  rd0           rd1           rd2           b0 b1 a0
      addVec(1, 0,  32'h1234,     1, 0,  0, 0,  0,  0,   0,            0,            0,            0, 0, 0);
      addVec(1, 3,  32'hA5A5A5A5, 0, 0,  0, 3,  3,  3,   32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0);
      addVec(0, 0,  0,            0, 0,  0, 3,  0,  3,   32'hA5A5A5A5, 0,            32'hA5A5A5A5, 0, 0, 0);
      addVec(0, 0,  0,            1, 12, 0, 12, 3,  12,  0,            32'hA5A5A5A5, 0,            0, 0, 0);
      addVec(0, 0,  0,            0, 0,  0, 12, 12, 0,   0,            0,            0,            1, 1, 0);
      addVec(0, 0,  0,            0, 0,  0, 12, 0,  0,   0,            0,            0,            1, 0, 0);
      addVec(1, 12, 32'd7,        0, 0,  0, 12, 0,  12,  32'd7,        0,            32'd7,        0, 0, 0);
      addVec(0, 0,  0,            0, 0,  0, 12, 0,  0,   32'd7,        0,            0,            0, 0, 0);
      addVec(1, 12, 32'd8,        1, 12, 0, 12, 0,  0,   32'd8,        0,            0,            0, 0, 0);
      addVec(0, 0,  0,            0, 0,  0, 12, 0,  0,   32'd8,        0,            0,            1, 0, 0);
      addVec(1, 5,  32'h99,       0, 0,  1, 5,  5,  5,   32'h99,       32'h99,       32'h99,       0, 0, 0);
      addVec(0, 0,  0,            0, 0,  0, 5,  0,  5,   32'd1,        0,            32'd1,        0, 0, 0);
      addVec(1, 10, 32'hFF,       0, 0,  0, 10, 0,  10,  32'hFF,       0,            32'hFF,       0, 0, 0);
      addVec(0, 0,  0,            0, 0,  0, 10, 12, 10,  32'hFF,       32'd8,        32'hFF,       0, 1, 32'hFF);

      // Reset state, while rst is still asserted.
      #2;
      checkOutput("reset");
      checkVal("reset rd7", bus2.rd[31:0], 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int n = 0; n < vecs.size(); n++) begin
         applyStimulus(vecs[n].we, vecs[n].wa, vecs[n].wd, vecs[n].ce, vecs[n].ca,
                       vecs[n].trig, vecs[n].ra0, vecs[n].ra1, vecs[n].ra2);
         @(negedge clk);
         checkVal($sformatf("vec%0d rd0", n), bus2.rd[31:0], vecs[n].expRd0);
         checkVal($sformatf("vec%0d rd1", n), bus2.rd[63:32], vecs[n].expRd1);
         checkVal($sformatf("vec%0d rd3p2", n), bus3.rd[95:64], vecs[n].expRd2);
         checkVal($sformatf("vec%0d busy0", n), 32'(bus2.busy[0]), 32'(vecs[n].expBusy0));
         checkVal($sformatf("vec%0d busy1", n), 32'(bus2.busy[1]), 32'(vecs[n].expBusy1));
         checkVal($sformatf("vec%0d a0", n), bus2.a0, vecs[n].expA0);
         checkOutput($sformatf("vec%0d", n));
         tick();
      end

      // Mid-cycle reset: x7 written and claimed, then cleared asynchronously.
      applyStimulus(1, 7, 32'hDEADBEEF, 0, 0, 0, 7, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 1, 7, 0, 7, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 7, 10, 7);
      #2;
      checkVal("prereset rd7", bus2.rd[31:0], 32'hDEADBEEF);
      checkVal("prereset busy7", 32'(bus2.busy[0]), 32'd1);
      rst = 1'b1;
      #1;
      modelReset();
      checkVal("midreset rd7", bus2.rd[31:0], 32'd0);
      checkVal("midreset busy", 32'(bus2.busy[0]), 32'd0);
      checkVal("midreset a0", bus2.a0, 32'd0);
      checkOutput("midreset");
      // Inputs presented while reset is held must not land.
      applyStimulus(1, 7, 32'h55, 1, 7, 1, 7, 5, 7);
      @(posedge clk);
      #1;
      applyStimulus(0, 0, 0, 0, 0, 0, 7, 5, 10);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("postreset");
      tick();

      // Randomised traffic against the model.
      for (int n = 0; n < 300; n++) begin
         applyStimulus(($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom(),
                       ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
                       ($urandom_range(0, 15) == 0),
                       5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)));
         @(negedge clk);
         checkOutput($sformatf("rand%0d", n));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
